// File: rtl/sa_operand_sequencer_if.sv
// Operand stream and skewed array-side bundle for sa_operand_sequencer.
// slave = sequencer, master = upstream feeder / observer.
interface sa_operand_sequencer_if #(
   parameter int N  = 4,
   parameter int DW = 8,
   parameter int KW = 9
);
   logic          abort_i;
   logic          in_valid_i;
   logic          in_ready_o;
   logic          in_last_i;
   logic [N*DW-1:0] a_i;
   logic [N*DW-1:0] b_i;
   logic [N*DW-1:0] a_o;
   logic [N*DW-1:0] b_o;
   logic [N-1:0]  last_o;
   logic          ctrl_o;
   logic          busy_o;
   logic          done_o;
   logic          kovf_o;
   logic [KW-1:0] beat_cnt_o;

   modport master (
      output abort_i, in_valid_i, in_last_i, a_i, b_i,
      input  in_ready_o, a_o, b_o, last_o, ctrl_o,
      input  busy_o, done_o, kovf_o, beat_cnt_o
   );

   modport slave (
      input  abort_i, in_valid_i, in_last_i, a_i, b_i,
      output in_ready_o, a_o, b_o, last_o, ctrl_o,
      output busy_o, done_o, kovf_o, beat_cnt_o
   );
endinterface

// File: rtl/sa_operand_sequencer.sv
// Systolic-array operand front-end: diagonal skew of A/B beats,
// ctrl phase toggle, per-lane last, zero-fill drain and done pulse.
module sa_operand_sequencer #(
   parameter int N     = 4,
   parameter int DW    = 8,
   parameter int MAX_K = 256,
   parameter int DRAIN = 2*N-1
) (
   input logic clk_i,
   input logic rst_ni,
   sa_operand_sequencer_if.slave io
);
   localparam int KW  = $clog2(MAX_K+1);
   localparam int DCW = $clog2(DRAIN+1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FEED,
      S_FLUSH,
      S_DONE
   } state_t;

   state_t         state_q, state_d;
   logic [KW-1:0]  cnt_q, cnt_d;
   logic [DCW-1:0] drain_q, drain_d;
   logic           ctrl_q, ctrl_d;
   logic           ready;
   logic           accept;
   logic           eff_last;
   logic           busy;

   assign busy     = (state_q == S_FEED) || (state_q == S_FLUSH);
   assign ready    = ((state_q == S_IDLE) || (state_q == S_FEED))
                     && !io.abort_i;
   assign accept   = io.in_valid_i && ready;
   assign eff_last = io.in_last_i || (cnt_q == KW'(MAX_K-1));

   assign io.in_ready_o = ready;
   assign io.busy_o     = busy;
   assign io.done_o     = (state_q == S_DONE);
   assign io.kovf_o     = accept && eff_last && !io.in_last_i;
   assign io.ctrl_o     = ctrl_q;
   assign io.beat_cnt_o = cnt_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      drain_d = drain_q;
      ctrl_d  = busy ? !ctrl_q : ctrl_q;
      unique case (state_q)
         S_IDLE, S_FEED: begin
            if (accept) begin
               cnt_d = cnt_q + 1'b1;
               if (eff_last) begin
                  state_d = S_FLUSH;
                  drain_d = DCW'(DRAIN);
               end else begin
                  state_d = S_FEED;
               end
            end
         end
         S_FLUSH: begin
            drain_d = drain_q - 1'b1;
            if (drain_q == DCW'(1)) state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
         default: state_d = S_IDLE;
      endcase
      if (io.abort_i) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         drain_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         drain_q <= '0;
         ctrl_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         drain_q <= drain_d;
         ctrl_q  <= ctrl_d;
      end
   end

   // Lane i owns i+1 stages; idle/flush cycles shift zeros through.
   for (genvar i = 0; i < N; i++) begin : g_lane
      logic [DW-1:0] ra [0:i];
      logic [DW-1:0] rb [0:i];
      logic          rl [0:i];

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            for (int s = 0; s <= i; s++) begin
               ra[s] <= '0;
               rb[s] <= '0;
               rl[s] <= 1'b0;
            end
         end else if (io.abort_i) begin
            for (int s = 0; s <= i; s++) begin
               ra[s] <= '0;
               rb[s] <= '0;
               rl[s] <= 1'b0;
            end
         end else begin
            ra[0] <= accept ? io.a_i[i*DW +: DW] : '0;
            rb[0] <= accept ? io.b_i[i*DW +: DW] : '0;
            rl[0] <= accept && eff_last;
            for (int s = 1; s <= i; s++) begin
               ra[s] <= ra[s-1];
               rb[s] <= rb[s-1];
               rl[s] <= rl[s-1];
            end
         end
      end

      assign io.a_o[i*DW +: DW] = ra[i];
      assign io.b_o[i*DW +: DW] = rb[i];
      assign io.last_o[i]       = rl[i];
   end
endmodule

// File: tb/tb_sa_operand_sequencer.sv
// Scoreboard bench for sa_operand_sequencer: directed tiles push expected
// per-cycle outputs; negedge monitors pop and compare.
module tb_sa_operand_sequencer;
   localparam int N  = 4;
   localparam int DW = 8;
   localparam int D  = 2*N-1;

   logic clk = 1'b0;
   logic rst_ni = 1'b1;
   always #5 clk = ~clk;

   sa_operand_sequencer_if #(.N(N), .DW(DW), .KW(9)) ifa();
   sa_operand_sequencer_if #(.N(N), .DW(DW), .KW(2)) ifk();

   sa_operand_sequencer #(.N(N), .DW(DW), .MAX_K(256), .DRAIN(D)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .io(ifa)
   );
   sa_operand_sequencer #(.N(N), .DW(DW), .MAX_K(3), .DRAIN(D)) dut_k (
      .clk_i(clk), .rst_ni(rst_ni), .io(ifk)
   );

   typedef struct {
      logic [N*DW-1:0] a;
      logic [N*DW-1:0] b;
      logic [N-1:0]    last;
      logic busy, done, ready, kovf, chk_ctrl, ctrl;
      int   cnt;
   } rec_t;

   rec_t qa[$];
   rec_t qk[$];
   int   n_chk = 0;
   int   n_err = 0;

   logic [N*DW-1:0] g_a [24];
   logic [N*DW-1:0] g_b [24];
   logic            g_v [24];
   logic            g_il[24];
   int              g_L;
   int              g_kovf;
   bit              g_fresh;

   function automatic logic [N*DW-1:0] pk(int x0, int x1, int x2, int x3);
      return {8'(x3), 8'(x2), 8'(x1), 8'(x0)};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cmp(input string t, input rec_t r,
                      input logic [N*DW-1:0] a, input logic [N*DW-1:0] b,
                      input logic [N-1:0] l, input logic bz, input logic dn,
                      input logic rd, input logic kv, input logic ct,
                      input int cn);
      chk({t, ".a_o"}, a, r.a);
      chk({t, ".b_o"}, b, r.b);
      chk({t, ".last_o"}, l, r.last);
      chk({t, ".busy_o"}, bz, r.busy);
      chk({t, ".done_o"}, dn, r.done);
      chk({t, ".in_ready_o"}, rd, r.ready);
      chk({t, ".kovf_o"}, kv, r.kovf);
      chk({t, ".beat_cnt_o"}, cn, r.cnt);
      if (r.chk_ctrl) chk({t, ".ctrl_o"}, ct, r.ctrl);
   endtask

   // Expected outputs c cycles after the first acceptance edge:
   // lane i shows the slot offered i+1 cycles earlier.
   function automatic rec_t mk(int c, bit ab);
      rec_t r;
      int s;
      int cc;
      r.a = '0;
      r.b = '0;
      r.last = '0;
      for (int i = 0; i < N; i++) begin
         s = c - 1 - i;
         if (s >= 0 && s < g_L && g_v[s]) begin
            r.a[i*DW +: DW] = g_a[s][i*DW +: DW];
            r.b[i*DW +: DW] = g_b[s][i*DW +: DW];
            r.last[i] = (s == g_L - 1);
         end
      end
      r.busy  = (c <= g_L - 1 + D);
      r.done  = (c == g_L + D);
      r.ready = ((c <= g_L - 1) || (c > g_L + D)) && !ab;
      r.kovf  = (c == g_kovf);
      r.cnt   = 0;
      if (c <= g_L + D)
         for (int s2 = 0; s2 < c && s2 < g_L; s2++)
            if (g_v[s2]) r.cnt++;
      cc = (c < g_L + D) ? c : g_L + D;
      r.chk_ctrl = g_fresh;
      r.ctrl = ((cc - 1) % 2 == 0);
      return r;
   endfunction

   function automatic rec_t idle_rec();
      rec_t r;
      r.a = '0;
      r.b = '0;
      r.last = '0;
      r.busy = 0;
      r.done = 0;
      r.ready = 1;
      r.kovf = 0;
      r.chk_ctrl = 0;
      r.ctrl = 0;
      r.cnt = 0;
      return r;
   endfunction

   task automatic push(input int which, input rec_t r);
      if (which == 0) qa.push_back(r);
      else qk.push_back(r);
   endtask

   task automatic idle_all();
      ifa.abort_i = 0; ifa.in_valid_i = 0; ifa.in_last_i = 0;
      ifa.a_i = '0; ifa.b_i = '0;
      ifk.abort_i = 0; ifk.in_valid_i = 0; ifk.in_last_i = 0;
      ifk.a_i = '0; ifk.b_i = '0;
   endtask

   task automatic drive(input int which, input int s, input bit ab);
      if (which == 0) begin
         ifa.in_valid_i = g_v[s]; ifa.in_last_i = g_il[s];
         ifa.a_i = g_a[s]; ifa.b_i = g_b[s]; ifa.abort_i = ab;
      end else begin
         ifk.in_valid_i = g_v[s]; ifk.in_last_i = g_il[s];
         ifk.a_i = g_a[s]; ifk.b_i = g_b[s]; ifk.abort_i = ab;
      end
   endtask

   task automatic clr();
      for (int i = 0; i < 24; i++) begin
         g_a[i] = '0; g_b[i] = '0; g_v[i] = 0; g_il[i] = 0;
      end
      g_kovf = -1;
   endtask

   task automatic load_base();
      clr();
      g_a[0] = pk(4,1,2,3); g_a[1] = pk(7,8,5,6);
      g_a[2] = pk(2,3,4,1); g_a[3] = pk(6,7,8,5);
      g_b[0] = pk(1,5,3,8); g_b[1] = pk(2,6,4,5);
      g_b[2] = pk(3,7,1,6); g_b[3] = pk(4,8,2,7);
      for (int i = 0; i < 4; i++) g_v[i] = 1;
      g_il[3] = 1;
      g_L = 4;
   endtask

   task automatic load_bubble();
      load_base();
      g_a[4] = g_a[3]; g_b[4] = g_b[3];
      g_a[3] = g_a[2]; g_b[3] = g_b[2];
      g_a[2] = pk(9,9,9,9); g_b[2] = pk(9,9,9,9);
      g_v[2] = 0; g_v[4] = 1;
      g_il[3] = 0; g_il[4] = 1;
      g_L = 5;
   endtask

   task automatic load_single();
      clr();
      g_a[0] = pk(11,22,33,44); g_b[0] = pk(55,66,77,88);
      g_v[0] = 1; g_il[0] = 1;
      g_L = 1;
   endtask

   task automatic load_kovf();
      clr();
      for (int s = 0; s < 4; s++) begin
         g_a[s] = pk(10+s, 20+s, 30+s, 40+s);
         g_b[s] = pk(50+s, 60+s, 70+s, 80+s);
      end
      for (int s = 0; s < 10; s++) g_v[s] = 1;
      for (int s = 4; s < 10; s++) begin
         g_a[s] = g_a[3]; g_b[s] = g_b[3];
      end
      g_L = 3;
      g_kovf = 2;
   endtask

   task automatic wait_empty();
      for (int i = 0; i < 100 && (qa.size() > 0 || qk.size() > 0); i++)
         @(posedge clk);
      if (qa.size() > 0 || qk.size() > 0) begin
         n_chk++;
         n_err++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0",
                  qa.size() + qk.size());
         qa.delete();
         qk.delete();
      end
   endtask

   // mode 0: full tile, 1: abort at slot cut, 2: async reset after slot cut
   task automatic run(input int which, input int mode, input int cut);
      int nrec;
      @(posedge clk);
      #1;
      drive(which, 0, 0);
      @(posedge clk);
      nrec = (mode == 0) ? g_L + D + 1 : cut;
      for (int c = 1; c <= nrec; c++)
         push(which, mk(c, mode == 1 && c == cut));
      if (mode == 1)
         for (int c = 1; c <= 3; c++) push(which, idle_rec());
      for (int s = 1; s <= nrec; s++) begin
         #1;
         drive(which, s, mode == 1 && s == cut);
         @(posedge clk);
      end
      if (mode == 2) begin
         #2;
         rst_ni = 0;
         idle_all();
         #10;
         rst_ni = 1;
      end else begin
         #1;
         idle_all();
      end
      wait_empty();
   endtask

   rec_t ra_r, rk_r;
   bit   pva = 0, pvk = 0;
   logic pba, pca, pbk, pck, nca, nck;

   always @(negedge clk) begin
      if (rst_ni) begin
         if (qa.size() > 0) begin
            ra_r = qa.pop_front();
            cmp("dut", ra_r, ifa.a_o, ifa.b_o, ifa.last_o, ifa.busy_o,
                ifa.done_o, ifa.in_ready_o, ifa.kovf_o, ifa.ctrl_o,
                int'(ifa.beat_cnt_o));
         end
         if (pva) begin
            nca = pba ? !pca : pca;
            chk("dut.ctrl_toggle", ifa.ctrl_o, nca);
         end
         pva = 1; pba = ifa.busy_o; pca = ifa.ctrl_o;
      end else begin
         pva = 0;
      end
   end

   always @(negedge clk) begin
      if (rst_ni) begin
         if (qk.size() > 0) begin
            rk_r = qk.pop_front();
            cmp("dut_k", rk_r, ifk.a_o, ifk.b_o, ifk.last_o, ifk.busy_o,
                ifk.done_o, ifk.in_ready_o, ifk.kovf_o, ifk.ctrl_o,
                int'(ifk.beat_cnt_o));
         end
         if (pvk) begin
            nck = pbk ? !pck : pck;
            chk("dut_k.ctrl_toggle", ifk.ctrl_o, nck);
         end
         pvk = 1; pbk = ifk.busy_o; pck = ifk.ctrl_o;
      end else begin
         pvk = 0;
      end
   end

   always @(negedge rst_ni) begin
      #1;
      chk("rst.a_o", ifa.a_o, 0);
      chk("rst.b_o", ifa.b_o, 0);
      chk("rst.last_o", ifa.last_o, 0);
      chk("rst.beat_cnt_o", ifa.beat_cnt_o, 0);
      chk("rst.ctrl_o", ifa.ctrl_o, 1);
      chk("rst.busy_o", ifa.busy_o, 0);
      chk("rst.done_o", ifa.done_o, 0);
      chk("rst.kovf_o", ifa.kovf_o, 0);
      chk("rst_k.a_o", ifk.a_o, 0);
      chk("rst_k.ctrl_o", ifk.ctrl_o, 1);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_all();
      clr();
      g_L = 1;
      g_fresh = 0;
      #2 rst_ni = 0;
      #20 rst_ni = 1;
      load_base();   g_fresh = 1; run(0, 0, 0);
      g_fresh = 0;
      load_bubble(); run(0, 0, 0);
      load_single(); run(0, 0, 0);
      load_kovf();   g_fresh = 1; run(1, 0, 0);
      g_fresh = 0;
      load_base();   run(0, 1, 2); run(0, 0, 0);
      load_base();   run(0, 1, 6); run(0, 0, 0);
      load_base();   run(0, 2, 2);
      g_fresh = 1;   run(0, 0, 0);
      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
